// File: rtl/multi_stepper_ctrl.sv
// multi_stepper_ctrl: multi-channel unipolar stepper sequencer with
// per-channel rate divider, 8-entry phase table and position counter.
module multi_stepper_ctrl #(
   parameter int NUM_CH = 2,
   parameter int STEP_W = 16,
   parameter int DIV_W  = 20,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [CH_W-1:0]          cmd_ch,
   input  logic [STEP_W-1:0]        cmd_steps,
   input  logic [DIV_W-1:0]         cmd_period,
   input  logic                     cmd_half,
   input  logic [NUM_CH-1:0]        stop,
   output logic [4*NUM_CH-1:0]      coils,
   output logic [NUM_CH-1:0]        busy,
   output logic [NUM_CH-1:0]        done,
   output logic [NUM_CH*STEP_W-1:0] position
);

   typedef enum logic {IDLE, RUN} state_t;

   function automatic logic [3:0] phase(input logic [2:0] i);
      logic [3:0] p;
      case (i)
         3'd0:    p = 4'b1000;
         3'd1:    p = 4'b1100;
         3'd2:    p = 4'b0100;
         3'd3:    p = 4'b0110;
         3'd4:    p = 4'b0010;
         3'd5:    p = 4'b0011;
         3'd6:    p = 4'b0001;
         default: p = 4'b1001;
      endcase
      return p;
   endfunction

   logic [NUM_CH-1:0] sel;
   logic [NUM_CH-1:0] ok;
   logic [NUM_CH-1:0] acc;
   logic              cmd_neg;
   logic [STEP_W-1:0] cmd_mag;
   logic [DIV_W-1:0]  cmd_reload;

   // magnitude of the most-negative count wraps to 2^(STEP_W-1) naturally
   assign cmd_neg    = cmd_steps[STEP_W-1];
   assign cmd_mag    = cmd_neg ? (~cmd_steps + STEP_W'(1)) : cmd_steps;
   assign cmd_reload = (cmd_period == '0) ? '0
                     : cmd_period - DIV_W'(1);
   assign acc        = ok & {NUM_CH{cmd_valid}};
   assign cmd_ready  = |ok;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [CH_W-1:0] ID = CH_W'(c);

      state_t            st;
      logic [2:0]        idx;
      logic [2:0]        inc;
      logic              en;
      logic              neg;
      logic              half;
      logic              dn;
      logic [STEP_W-1:0] pos;
      logic [STEP_W-1:0] rem;
      logic [DIV_W-1:0]  div;
      logic [DIV_W-1:0]  reload;

      assign sel[c] = (cmd_ch == ID);
      assign ok[c]  = sel[c] && (st == IDLE) && !stop[c];
      assign inc    = half ? 3'd1 : 3'd2;

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            st     <= IDLE;
            idx    <= '0;
            en     <= 1'b0;
            neg    <= 1'b0;
            half   <= 1'b0;
            dn     <= 1'b0;
            pos    <= '0;
            rem    <= '0;
            div    <= '0;
            reload <= '0;
         end else begin
            dn <= 1'b0;
            case (st)
               IDLE: begin
                  if (acc[c]) begin
                     en <= 1'b1;
                     if (cmd_mag == '0) begin
                        dn <= 1'b1;
                     end else begin
                        st     <= RUN;
                        neg    <= cmd_neg;
                        half   <= cmd_half;
                        rem    <= cmd_mag;
                        div    <= cmd_reload;
                        reload <= cmd_reload;
                     end
                  end
               end
               RUN: begin
                  // abort beats a coincident step edge
                  if (stop[c]) begin
                     st <= IDLE;
                  end else if (div != '0) begin
                     div <= div - DIV_W'(1);
                  end else begin
                     idx <= neg ? idx - inc : idx + inc;
                     pos <= neg ? pos - STEP_W'(1)
                                : pos + STEP_W'(1);
                     rem <= rem - STEP_W'(1);
                     div <= reload;
                     if (rem == STEP_W'(1)) begin
                        st <= IDLE;
                        dn <= 1'b1;
                     end
                  end
               end
            endcase
         end
      end

      assign coils[4*c +: 4]             = en ? phase(idx) : 4'b0000;
      assign busy[c]                     = (st == RUN);
      assign done[c]                     = dn;
      assign position[c*STEP_W +: STEP_W] = pos;
   end

endmodule

// File: doc/multi_stepper_ctrl.md
# multi_stepper_ctrl

Parametrised multi-channel unipolar stepper-motor sequencer. It sits between the processor's memory-mapped IO path and the Pmod header pins, and supersedes the single fixed-channel coil driver. Each channel accepts a signed step-count command with a programmable step period and a full/half-step mode. Each channel runs its own rate divider and phase sequencer, and reports busy, done and absolute position.

## Interface
- NUM_CH, 2, number of independent motor channels (1..8)
- STEP_W, 16, width of step count and position counters
- DIV_W, 20, width of the step-period divider (clock cycles per step)
- CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), channel-select width (derived)

- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- cmd_valid  in  1  command present
- cmd_ready  out  1  addressed channel can accept (combinational)
- cmd_ch  in  CH_W  target channel; values >= NUM_CH: cmd_ready=0
- cmd_steps  in  STEP_W  signed step count; sign = direction
- cmd_period  in  DIV_W  cycles per step; 0 treated as 1
- cmd_half  in  1  1 = half-step mode, 0 = full-step mode
- stop  in  NUM_CH  per-channel abort request (level)
- coils  out  4*NUM_CH  coil drive; channel c on bits [4c+3:4c] = {A,B,C,D}
- busy  out  NUM_CH  channel in RUN
- done  out  NUM_CH  one-cycle pulse on normal completion
- position  out  NUM_CH*STEP_W  signed absolute step count per channel

## Operation
- Per-channel FSM with states IDLE and RUN. Reset sets IDLE, phase idx=0, position=0, energised=0, so coils=0000, busy=0, done=0.
- The phase table is 8-entry, indexed by idx: 0:1000 1:1100 2:0100 3:0110 4:0010 5:0011 6:0001 7:1001.
- Coils output table[idx] when energised=1, else 0000. energised is set on the first accepted command and cleared only by reset. In IDLE the last phase is held for holding torque.
- cmd_ready = (channel cmd_ch is IDLE) and !stop[cmd_ch] and cmd_ch < NUM_CH.
- A command is accepted when cmd_valid & cmd_ready at a clock edge. Accepting latches dir=sign(cmd_steps), remaining=|cmd_steps| (unsigned STEP_W; the most-negative value gives 2^(STEP_W-1)), mode, divider=max(cmd_period,1)-1.
- If cmd_steps=0: the channel stays IDLE, done pulses the next cycle, energised is set, and nothing else changes.
- RUN, each cycle:
  - If divider!=0, decrement the divider.
  - Otherwise take a step: idx += dir*(half?1:2) mod 8, position += dir*1 (mod 2^STEP_W, wraps), remaining -= 1, divider reloads.
  - When remaining reaches 0 on that step, go to IDLE and pulse done.
- Full-step mode keeps the parity of idx. Odd idx therefore yields two-coil full steps and even idx yields one-coil full steps. This is intended.
- stop[c] in RUN forces IDLE at the next edge. There is no done pulse, idx and position keep their current values, and the remaining count is discarded. stop in IDLE has no effect.
- Channels are fully independent. Only one command is accepted per cycle, selected by cmd_ch.

## Timing
- Acceptance at edge T0 sets busy=1 from T0.
- Step k (k=1..N) changes coils and position at edge T0 + k*P, where P = max(cmd_period,1).
- On the final step edge, busy falls. done is high during the cycle following that edge, for exactly one cycle.
- The earliest new command on the same channel is accepted at the final step edge + 1 cycle, i.e. the cycle when done is high. cmd_ready is already high then.
- P=1 gives one step per cycle with no bubbles.
- A stop asserted during cycle before edge E leaves busy=0 after E. If E coincides with a step edge, stop wins and no step occurs.
- A reset assertion mid-run clears everything asynchronously. coils go to 0000 without waiting for a clock.

## Test plan
- Reset, then NUM_CH=2, ch0 steps=+4, period=3, half=1 → coils0 1100,0100,0110,0010 at T0+3,6,9,12. position0=4. busy0 falls at T0+12 and done0 pulses one cycle. coils1 stays 0000.
- ch1 steps=-3, period=0, full → one step per cycle. idx 0→6→4→2, coils1 0001,0010,0100. position1=-3 (0xFFFD).
- ch0 steps=+100, period=5 with stop0 asserted after 7 steps → busy0 low, no done0 pulse, position0=7, coils hold the 7th phase. A new command is then accepted.
- Command to a busy channel → cmd_ready=0, command ignored. Simultaneous command to the idle other channel → accepted, and both run concurrently with independent periods 2 and 7.
- steps=0 command → done pulses next cycle, busy never rises, coils go from 0000 to 1000 (energised).
- STEP_W=4: position at +7 plus one step wraps to -8. steps=-8 (0x8) executes 8 steps. Reset asserted mid-run → all outputs 0 immediately.
